mprj_flash_io_player: RTL and testbench

- Simplified Caravel-style management block.
- After reset it fetches a byte stream from an external SPI flash (spiflash model compatible, standard read) and plays each byte on user-project GPIO pads mprj_io[7:0].
- Used as the DUT for GPIO bring-up sequences such as 01..0A, FF, 00.
- Pads [37:8] stay inputs.

---
 rtl/mprj_flash_io_player.sv | 196 +++++++++++++++++++
 tb/tb_mprj_flash_io_player.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_flash_io_player.sv
// mprj_flash_io_player
// Simplified Caravel-style management block. After reset it issues a single
// SPI flash read at START_ADDR and plays the returned byte stream on the
// user GPIO pads mprj_io[7:0], one byte every HOLD_CYCLES+16 clocks, until
// a 0x00 byte has been displayed. The flash transaction is paused (SCK low,
// CSB low) between bytes, so no address counter is needed.
//
// Optional build macro FLASH_FAST_READ_EN: use fast read (0x0B) with eight
// dummy SCK periods after the address instead of standard read (0x03).
module mprj_flash_io_player #(
  parameter logic [23:0] START_ADDR    = 24'h000000,
  parameter int          HOLD_CYCLES   = 16,
  parameter int          STARTUP_DELAY = 8
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  output logic [37:0] mprj_io_out,
  output logic [37:0] mprj_io_oeb,
  output logic        done
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  // Terminal values of the shared wait counter (startup delay and byte hold).
  localparam logic [15:0] STARTUP_LAST = (STARTUP_DELAY > 1) ? 16'(STARTUP_DELAY - 1) : 16'd0;
  localparam logic [15:0] HOLD_LAST    = (HOLD_CYCLES > 1) ? 16'(HOLD_CYCLES) : 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef FLASH_FAST_READ_EN
    S_DUMMY,
`endif
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        ph_q;      // 0: next edge is the SCK-low half, 1: next edge raises SCK
  logic [4:0]  bit_q;     // SCK periods completed in the current shift state
  logic [31:0] sr_q;      // outgoing command + address, MSB first
  logic [6:0]  rx_q;      // first seven bits of the incoming byte
  logic [15:0] wait_q;    // startup delay / hold counter
  logic        csb_q;
  logic        sck_q;
  logic        io0_q;
  logic [7:0]  out_q;
  logic        oeb_q;     // common output enable for pads [7:0]
  logic        done_q;
  logic [7:0]  rx_byte_d;

  // Complete byte as it stands on the edge that captures its last bit.
  assign rx_byte_d = {rx_q, flash_io1};

  assign flash_csb   = csb_q;
  assign flash_clk   = sck_q;
  assign flash_io0   = io0_q;
  assign done        = done_q;
  assign mprj_io_out = {30'd0, out_q};
  assign mprj_io_oeb = {30'h3FFF_FFFF, {8{oeb_q}}};

  // Flash sequencer, SPI bit engine and pad registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      bit_q   <= 5'd0;
      sr_q    <= 32'd0;
      rx_q    <= 7'd0;
      wait_q  <= 16'd0;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      io0_q   <= 1'b0;
      out_q   <= 8'd0;
      oeb_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wait_q == STARTUP_LAST) begin
            wait_q  <= 16'd0;
            csb_q   <= 1'b0;
            ph_q    <= 1'b0;
            bit_q   <= 5'd0;
            sr_q    <= {CMD_BYTE, START_ADDR};
            state_q <= S_CMD;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end

`ifdef FLASH_FAST_READ_EN
        S_CMD, S_ADDR, S_DUMMY, S_READ: begin
`else
        S_CMD, S_ADDR, S_READ: begin
`endif
          if (!ph_q) begin
            // SCK low half: MOSI may change only here.
            sck_q <= 1'b0;
            ph_q  <= 1'b1;
            if (state_q == S_CMD || state_q == S_ADDR) begin
              io0_q <= sr_q[31];
              sr_q  <= {sr_q[30:0], 1'b0};
            end else begin
              io0_q <= 1'b0;
            end
          end else begin
            // SCK rising edge: MISO is sampled on this same clock edge.
            sck_q <= 1'b1;
            ph_q  <= 1'b0;
            bit_q <= bit_q + 5'd1;
            if (state_q == S_READ) begin
              rx_q <= rx_byte_d[6:0];
            end
            unique case (state_q)
              S_CMD: begin
                if (bit_q == 5'd7) begin
                  bit_q   <= 5'd0;
                  state_q <= S_ADDR;
                end
              end
              S_ADDR: begin
                if (bit_q == 5'd23) begin
                  bit_q   <= 5'd0;
`ifdef FLASH_FAST_READ_EN
                  state_q <= S_DUMMY;
`else
                  state_q <= S_READ;
`endif
                end
              end
`ifdef FLASH_FAST_READ_EN
              S_DUMMY: begin
                if (bit_q == 5'd7) begin
                  bit_q   <= 5'd0;
                  state_q <= S_READ;
                end
              end
`endif
              S_READ: begin
                if (bit_q == 5'd7) begin
                  bit_q   <= 5'd0;
                  out_q   <= rx_byte_d;
                  oeb_q   <= 1'b0;
                  wait_q  <= 16'd1;
                  state_q <= S_HOLD;
                end
              end
              default: ;
            endcase
          end
        end

        S_HOLD: begin
          // Transaction paused: SCK parked low, CSB kept low.
          sck_q <= 1'b0;
          io0_q <= 1'b0;
          if (wait_q == HOLD_LAST) begin
            wait_q <= 16'd0;
            if (out_q == 8'h00) begin
              csb_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ph_q    <= 1'b0;
              bit_q   <= 5'd0;
              state_q <= S_READ;
            end
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end

        S_DONE: begin
          csb_q  <= 1'b1;
          sck_q  <= 1'b0;
          io0_q  <= 1'b0;
          done_q <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_flash_io_player.sv
// Self-checking bench for mprj_flash_io_player with a behavioural SPI flash
// model (read command, 24-bit address, optional dummy byte, data on SCK
// falling edges). Define FLASH_FAST_READ_EN to check the fast-read build.
module tb_mprj_flash_io_player;
  localparam logic [23:0] START_ADDR = 24'h000000;
  localparam int HOLD   = 16;
  localparam int SDLY   = 8;
  localparam int PERIOD = HOLD + 16;
`ifdef FLASH_FAST_READ_EN
  localparam int HDR = 40;
  localparam logic [39:0] EXP_HDR = {8'h0B, START_ADDR, 8'h00};
`else
  localparam int HDR = 32;
  localparam logic [39:0] EXP_HDR = {8'h00, 8'h03, START_ADDR};
`endif

  logic        clock  = 1'b0;
  logic        resetb = 1'b0;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  logic [37:0] mprj_io_out, mprj_io_oeb;
  logic        done;
  logic        pad3_ext = 1'b1;   // external housekeeping-CSB driver on pad 3

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mprj_flash_io_player #(
    .START_ADDR(START_ADDR), .HOLD_CYCLES(HOLD), .STARTUP_DELAY(SDLY)
  ) dut (
    .clock(clock), .resetb(resetb),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .mprj_io_out(mprj_io_out), .mprj_io_oeb(mprj_io_oeb),
    .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- SPI flash model ----------------
  logic [7:0]  mem [0:255];
  logic [31:0] fl_sr = 32'd0;
  int          fl_rise = 0;
  int          fl_k;
  logic [7:0]  fl_byte;
  logic [2:0]  fl_bit;

  always_comb begin
    fl_k    = fl_rise - HDR;
    fl_byte = fl_sr[7:0] + 8'(fl_k / 8);
    fl_bit  = 3'(7 - (fl_k % 8));
  end

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fl_rise <= 0;
    end else begin
      if (fl_rise < 32) fl_sr <= {fl_sr[30:0], flash_io0};
      fl_rise <= fl_rise + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fl_rise >= HDR) flash_io1 <= mem[fl_byte][fl_bit];
  end

  // ---------------- bench state ----------------
  logic [7:0] img[$];
  logic [7:0] exp_q[$];
  logic [7:0] ev_val[$];
  int         ev_cyc[$];
  int         done_cyc;
  bit         cap_timeout;
  int         pre_bad;
  int         upper_bad;

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < img.size(); i++) mem[8'(START_ADDR[7:0] + 8'(i))] = img[i];
  endtask

  // Reference: the pads show the image in order up to and including the first 00.
  task automatic build_expected();
    exp_q.delete();
    foreach (img[i]) begin
      exp_q.push_back(img[i]);
      if (img[i] == 8'h00) break;
    end
  endtask

  task automatic apply_reset(input int n);
    resetb = 1'b0;
    repeat (n) @(negedge clock);
    resetb = 1'b1;
  endtask

  // Records each newly displayed byte (first one when pads turn to outputs).
  task automatic capture_stream(input int max_ev, input int budget);
    logic [7:0] prev_out;
    bit loaded;
    bit finished;
    int n;
    ev_val.delete(); ev_cyc.delete();
    done_cyc = -1; cap_timeout = 1'b0; pre_bad = 0; upper_bad = 0;
    loaded = 1'b0; finished = 1'b0; prev_out = 8'h00; n = 0;
    while (!finished && n < budget) begin
      @(negedge clock);
      n++;
      if (mprj_io_out[37:8] !== 30'd0 || mprj_io_oeb[37:8] !== 30'h3FFF_FFFF) upper_bad++;
      if (!loaded) begin
        if (mprj_io_oeb[7:0] === 8'h00) begin
          loaded = 1'b1; prev_out = mprj_io_out[7:0];
          ev_val.push_back(mprj_io_out[7:0]); ev_cyc.push_back(cyc);
        end else if (mprj_io_oeb[7:0] !== 8'hFF || mprj_io_out[7:0] !== 8'h00) begin
          pre_bad++;
        end
      end else if (mprj_io_out[7:0] !== prev_out) begin
        prev_out = mprj_io_out[7:0];
        ev_val.push_back(mprj_io_out[7:0]); ev_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin done_cyc = cyc; finished = 1'b1; end
      if (ev_val.size() >= max_ev) finished = 1'b1;
    end
    if (!finished) cap_timeout = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    bad = 0;
    resetb = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (flash_csb !== 1'b1 || flash_clk !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold: %0d bad samples, want 0", bad); end
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b want 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", flash_clk); end
    checks++; if (flash_io0 !== 1'b0) begin errors++; $display("FAIL reset_io0: got %b want 0", flash_io0); end
    checks++; if (mprj_io_oeb !== 38'h3F_FFFF_FFFF) begin errors++; $display("FAIL reset_oeb: got %h want 3fffffffff", mprj_io_oeb); end
    checks++; if (mprj_io_out !== 38'd0) begin errors++; $display("FAIL reset_out: got %h want 0", mprj_io_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_cmd_framing();
    int n, rises, last_rise, bad_period, bad_io0, csb_bad;
    logic prev_sck, prev_io0;
    logic [39:0] hdr_got;
    img = {8'h01, 8'h00};
    load_mem();
    apply_reset(4);
    n = 0;
    while (flash_csb === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n != SDLY) begin errors++; $display("FAIL csb_delay: got %0d want %0d", n, SDLY); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL sck_idle: got %b want 0", flash_clk); end
    rises = 0; last_rise = -1; bad_period = 0; bad_io0 = 0; csb_bad = 0; hdr_got = 40'd0;
    prev_sck = flash_clk; prev_io0 = flash_io0; n = 0;
    while (rises < HDR && n < 400) begin
      @(negedge clock);
      n++;
      if (flash_csb !== 1'b0) csb_bad++;
      if (flash_clk === 1'b1 && prev_sck === 1'b0) begin
        hdr_got = {hdr_got[38:0], flash_io0};
        if (last_rise >= 0 && cyc - last_rise != 2) bad_period++;
        last_rise = cyc;
        rises++;
      end
      if (flash_clk === 1'b1 && flash_io0 !== prev_io0) bad_io0++;
      prev_sck = flash_clk; prev_io0 = flash_io0;
    end
    checks++; if (rises != HDR) begin errors++; $display("FAIL hdr_rises: got %0d want %0d", rises, HDR); end
    checks++; if (hdr_got !== EXP_HDR) begin errors++; $display("FAIL hdr_bits: got %h want %h", hdr_got, EXP_HDR); end
    checks++; if (bad_period != 0) begin errors++; $display("FAIL sck_period: %0d bad periods, want 0", bad_period); end
    checks++; if (bad_io0 != 0) begin errors++; $display("FAIL io0_stable: %0d changes while SCK high, want 0", bad_io0); end
    checks++; if (csb_bad != 0) begin errors++; $display("FAIL hdr_csb: %0d samples with csb high, want 0", csb_bad); end
  endtask

  task automatic test_playback();
    int bad_iv, last;
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    load_mem(); build_expected();
    apply_reset(4);
    capture_stream(64, 3000);
    checks++; if (cap_timeout) begin errors++; $display("FAIL play_timeout: done never seen, want 1"); end
    checks++; if (ev_val.size() != exp_q.size()) begin errors++; $display("FAIL play_count: got %0d want %0d", ev_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= ev_val.size()) begin errors++; $display("FAIL play_byte[%0d]: got none want %h", i, exp_q[i]); end
      else if (ev_val[i] !== exp_q[i]) begin errors++; $display("FAIL play_byte[%0d]: got %h want %h", i, ev_val[i], exp_q[i]); end
    end
    bad_iv = 0;
    for (int i = 1; i < ev_cyc.size(); i++) if (ev_cyc[i] - ev_cyc[i-1] != PERIOD) bad_iv++;
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL play_period: %0d bad intervals, want 0 (period %0d)", bad_iv, PERIOD); end
    last = (ev_cyc.size() > 0) ? ev_cyc[ev_cyc.size()-1] : 0;
    checks++; if (done_cyc - last != HOLD) begin errors++; $display("FAIL done_delay: got %0d want %0d", done_cyc - last, HOLD); end
    repeat (3) @(negedge clock);
    checks++; if (done !== 1'b1 || flash_csb !== 1'b1 || flash_clk !== 1'b0) begin errors++; $display("FAIL done_state: got done=%b csb=%b sck=%b want 1 1 0", done, flash_csb, flash_clk); end
    checks++; if (mprj_io_out[7:0] !== 8'h00 || mprj_io_oeb[7:0] !== 8'h00) begin errors++; $display("FAIL done_pads: got out=%h oeb=%h want 00 00", mprj_io_out[7:0], mprj_io_oeb[7:0]); end
    checks++; if (upper_bad != 0) begin errors++; $display("FAIL upper_pads: %0d bad samples, want 0", upper_bad); end
  endtask

  task automatic test_pin3();
    img = {8'h01, 8'h02, 8'h00};
    load_mem();
    apply_reset(4);
    capture_stream(1, 1000);
    checks++; if (pre_bad != 0) begin errors++; $display("FAIL pin3_early: %0d samples with pads driven before first byte, want 0", pre_bad); end
    checks++; if (ev_val.size() != 1 || ev_val[0] !== 8'h01) begin errors++; $display("FAIL pin3_first: got %0d events want first byte 01", ev_val.size()); end
    checks++; if (mprj_io_oeb[3] !== 1'b0 || pad3_ext !== 1'b1) begin errors++; $display("FAIL pin3_oeb: got %b want 0", mprj_io_oeb[3]); end
  endtask

  task automatic test_reset_midstream();
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    load_mem(); build_expected();
    apply_reset(4);
    capture_stream(5, 2000);
    checks++; if (ev_val.size() != 5 || ev_val[4] !== 8'h05) begin errors++; $display("FAIL mid_reach05: got %0d events want 5 ending in 05", ev_val.size()); end
    #1 resetb = 1'b0;
    #1;
    checks++; if (flash_csb !== 1'b1 || flash_clk !== 1'b0 || flash_io0 !== 1'b0) begin errors++; $display("FAIL mid_spi: got csb=%b sck=%b io0=%b want 1 0 0", flash_csb, flash_clk, flash_io0); end
    checks++; if (mprj_io_out !== 38'd0 || mprj_io_oeb !== 38'h3F_FFFF_FFFF || done !== 1'b0) begin errors++; $display("FAIL mid_pads: got out=%h oeb=%h done=%b want 0 3fffffffff 0", mprj_io_out, mprj_io_oeb, done); end
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    capture_stream(64, 3000);
    checks++; if (cap_timeout || ev_val.size() != exp_q.size()) begin errors++; $display("FAIL mid_restart_count: got %0d want %0d", ev_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= ev_val.size()) begin errors++; $display("FAIL mid_byte[%0d]: got none want %h", i, exp_q[i]); end
      else if (ev_val[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte[%0d]: got %h want %h", i, ev_val[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int len;
      int bad_iv;
      logic [7:0] b, prev;
      len = (it == 0) ? 0 : int'($urandom_range(1, 20));
      img.delete(); prev = 8'h00;
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom_range(1, 255));
        while (j > 0 && b == prev) b = 8'($urandom_range(1, 255));
        img.push_back(b); prev = b;
      end
      img.push_back(8'h00);
      load_mem(); build_expected();
      apply_reset(3);
      capture_stream(64, 3000);
      checks++; if (cap_timeout || ev_val.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, ev_val.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= ev_val.size()) begin errors++; $display("FAIL rnd%0d_byte[%0d]: got none want %h", it, i, exp_q[i]); end
        else if (ev_val[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte[%0d]: got %h want %h", it, i, ev_val[i], exp_q[i]); end
      end
      bad_iv = 0;
      for (int i = 1; i < ev_cyc.size(); i++) if (ev_cyc[i] - ev_cyc[i-1] != PERIOD) bad_iv++;
      checks++; if (bad_iv != 0) begin errors++; $display("FAIL rnd%0d_period: %0d bad intervals, want 0", it, bad_iv); end
      checks++; if (ev_cyc.size() == 0 || done_cyc - ev_cyc[ev_cyc.size()-1] != HOLD) begin errors++; $display("FAIL rnd%0d_done: got done_cyc=%0d want %0d after last byte", it, done_cyc, HOLD); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_framing();
    test_playback();
    test_pin3();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
